exe_stage: RTL and testbench

Execute pipeline stage of the five-stage core, between the decode stage and the memory stage. It registers one decoded instruction, drives the `alu` operand and opcode ports, and stalls on multi-cycle multiply/divide until `alu_complete` is seen. It also issues the data-SRAM request for loads and stores, and publishes forwarding and interlock information back to decode.

---
 rtl/cpu_pkg.sv | 83 ++++++++
 rtl/exe_store_align.sv | 52 +++++
 rtl/exe_stage.sv | 135 +++++++++++++
 tb/tb_exe_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, bus layouts, ALU opcode bit indices and memory
// access sizes for the core pipeline stages.
package cpu_pkg;

  localparam int DS_BUS_W = 157;
  localparam int ES_BUS_W = 75;
  localparam int ALU_OP_W = 19;

  // Field offsets (LSB) inside ds_to_es_bus.
  localparam int DS_MEM_SIZE_LSB = 0;
  localparam int DS_RES_MEM_BIT  = 2;
  localparam int DS_MEM_WE_BIT   = 3;
  localparam int DS_GR_WE_BIT    = 4;
  localparam int DS_RD_LSB       = 5;
  localparam int DS_RKD_LSB      = 10;
  localparam int DS_SRC2_LSB     = 42;
  localparam int DS_SRC1_LSB     = 74;
  localparam int DS_ALU_OP_LSB   = 106;
  localparam int DS_PC_LSB       = 125;

  // Field offsets (LSB) inside es_to_ms_bus.
  localparam int ES_ADDR_LO_LSB  = 0;
  localparam int ES_MEM_SIZE_LSB = 2;
  localparam int ES_RES_MEM_BIT  = 4;
  localparam int ES_GR_WE_BIT    = 5;
  localparam int ES_RD_LSB       = 6;
  localparam int ES_RESULT_LSB   = 11;
  localparam int ES_PC_LSB       = 43;

  // One-hot ALU opcode bit indices.
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLT   = 2;
  localparam int ALU_SLTU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_NOR   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_XOR   = 7;
  localparam int ALU_SLL   = 8;
  localparam int ALU_SRL   = 9;
  localparam int ALU_SRA   = 10;
  localparam int ALU_LUI   = 11;
  localparam int ALU_MUL   = 12;
  localparam int ALU_MULH  = 13;
  localparam int ALU_MULHU = 14;
  localparam int ALU_DIV   = 15;
  localparam int ALU_MOD   = 16;
  localparam int ALU_DIVU  = 17;
  localparam int ALU_MODU  = 18;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rkd;
    logic [4:0]          rd;
    logic                gr_we;
    logic                mem_we;
    logic                res_from_mem;
    logic [1:0]          mem_size;
  } ds_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        gr_we;
    logic        res_from_mem;
    logic [1:0]  mem_size;
    logic [1:0]  addr_lo;
  } es_bus_t;

  // True for opcodes that need more than one cycle in the ALU.
  function automatic logic is_multicycle(input logic [ALU_OP_W-1:0] op);
    return |op[ALU_MODU:ALU_MUL];
  endfunction

endpackage

// File: rtl/exe_store_align.sv
// exe_store_align: byte-lane enables and replicated write data for stores.
// Loads and non-memory ops produce no lane enables.
module exe_store_align (
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rkd,
  output logic [3:0]  we,
  output logic [31:0] wdata
);
  import cpu_pkg::*;

  // Lane select and data replication by access size.
  always_comb begin
    we    = 4'b0000;
    wdata = rkd;
    case (mem_size)
      MEM_SIZE_B: begin
        wdata = {4{rkd[7:0]}};
        case (addr_lo)
          2'd0:    we = 4'b0001;
          2'd1:    we = 4'b0010;
          2'd2:    we = 4'b0100;
          2'd3:    we = 4'b1000;
          default: we = 4'b0000;
        endcase
      end
      MEM_SIZE_H: begin
        wdata = {2{rkd[15:0]}};
        if (addr_lo[1]) begin
          we = 4'b1100;
        end else begin
          we = 4'b0011;
        end
      end
      MEM_SIZE_W: begin
        wdata = rkd;
        we    = 4'b1111;
      end
      default: begin
        wdata = rkd;
        we    = 4'b0000;
      end
    endcase
    if (!mem_we) begin
      we = 4'b0000;
    end else begin
      we = we;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute pipeline stage. Holds one decoded instruction, drives
// the ALU, stalls on multi-cycle ops until alu_complete, issues the data-SRAM
// request and reports forwarding/interlock information to decode.
// Build option: define EXE_FORWARD_EN to forward the execute result to decode;
// without it any pending register write fully interlocks decode.
module exe_stage #(
  parameter int DS_BUS_W = cpu_pkg::DS_BUS_W,
  parameter int ES_BUS_W = cpu_pkg::ES_BUS_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ds_to_es_valid,
  input  logic [DS_BUS_W-1:0]         ds_to_es_bus,
  output logic                        es_allowin,
  input  logic                        ms_allowin,
  output logic                        es_to_ms_valid,
  output logic [ES_BUS_W-1:0]         es_to_ms_bus,
  output logic [cpu_pkg::ALU_OP_W-1:0] alu_op,
  output logic [31:0]                 alu_src1,
  output logic [31:0]                 alu_src2,
  input  logic [31:0]                 alu_result,
  input  logic                        alu_complete,
  output logic                        data_sram_en,
  output logic [3:0]                  data_sram_we,
  output logic [31:0]                 data_sram_addr,
  output logic [31:0]                 data_sram_wdata,
  output logic                        es_fwd_valid,
  output logic [4:0]                  es_fwd_rd,
  output logic [31:0]                 es_fwd_data,
  output logic                        es_fwd_block
);
  import cpu_pkg::*;

  ds_bus_t     es_bus_r;
  logic        es_valid;
  logic        done;
  logic [31:0] res_r;
  logic        es_ready_go;
  logic [31:0] result;
  logic        pending_write;
  es_bus_t     ms_bus;

  assign es_ready_go    = done | alu_complete;
  assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;

  // Instruction register: capture on accept, drop valid on a pure hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_bus_r <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_bus_r <= ds_to_es_bus;
      end
    end
  end

  // Hold the ALU result once it completes while the memory stage is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      res_r <= 32'd0;
    end else if (es_allowin & ds_to_es_valid) begin
      done <= 1'b0;
    end else if (es_valid & alu_complete & ~done & ~ms_allowin) begin
      done  <= 1'b1;
      res_r <= alu_result;
    end
  end

  // ALU opcode is withdrawn once the result is latched so no new op starts.
  always_comb begin
    alu_op = {ALU_OP_W{1'b0}};
    if (es_valid & ~done) begin
      alu_op = es_bus_r.alu_op;
    end else begin
      alu_op = {ALU_OP_W{1'b0}};
    end
  end

  assign alu_src1 = es_bus_r.src1;
  assign alu_src2 = es_bus_r.src2;

  // Stage result: latched copy after a backpressured completion, else live ALU.
  always_comb begin
    result = 32'd0;
    if (!es_valid) begin
      result = 32'd0;
    end else if (done) begin
      result = res_r;
    end else begin
      result = alu_result;
    end
  end

  // Memory request fires only in the hand-off cycle, hence once per instruction.
  assign data_sram_en   = es_valid & es_ready_go & ms_allowin &
                          (es_bus_r.mem_we | es_bus_r.res_from_mem);
  assign data_sram_addr = result;

  exe_store_align u_store_align (
    .mem_we   (es_bus_r.mem_we),
    .mem_size (es_bus_r.mem_size),
    .addr_lo  (result[1:0]),
    .rkd      (es_bus_r.rkd),
    .we       (data_sram_we),
    .wdata    (data_sram_wdata)
  );

  assign ms_bus.pc           = es_bus_r.pc;
  assign ms_bus.result       = result;
  assign ms_bus.rd           = es_bus_r.rd;
  assign ms_bus.gr_we        = es_bus_r.gr_we;
  assign ms_bus.res_from_mem = es_bus_r.res_from_mem;
  assign ms_bus.mem_size     = es_bus_r.mem_size;
  assign ms_bus.addr_lo      = result[1:0];
  assign es_to_ms_bus        = ms_bus;

  assign pending_write = es_valid & es_bus_r.gr_we & (es_bus_r.rd != 5'd0);
  assign es_fwd_rd     = es_bus_r.rd;

`ifdef EXE_FORWARD_EN
  assign es_fwd_valid = pending_write;
  assign es_fwd_data  = result;
  // Loads and unfinished ALU ops have no usable value yet.
  assign es_fwd_block = pending_write & (es_bus_r.res_from_mem | ~es_ready_go);
`else
  assign es_fwd_valid = 1'b0;
  assign es_fwd_data  = 32'd0;
  assign es_fwd_block = pending_write;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage. The bench plays
// both decode and the ALU; expected values are worked out by hand.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_es_valid;
  logic [156:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [74:0]  es_to_ms_bus;
  logic [18:0]  alu_op;
  logic [31:0]  alu_src1, alu_src2, alu_result;
  logic         alu_complete;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_rd;
  logic [31:0]  es_fwd_data;
  logic         es_fwd_block;

  int total = 0;
  int bad   = 0;

  localparam logic [18:0] OP_ADD = 19'h00001;
  localparam logic [18:0] OP_DIV = 19'h08000;

`ifdef EXE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .reset(reset),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_allowin(es_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_complete(alu_complete),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_rd(es_fwd_rd),
    .es_fwd_data(es_fwd_data), .es_fwd_block(es_fwd_block)
  );

  function automatic logic [156:0] mk(input logic [31:0] pc, input logic [18:0] op,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic [4:0] rd,
                                      input logic gw, input logic mw, input logic rfm,
                                      input logic [1:0] sz);
    return {pc, op, s1, s2, rkd, rd, gw, mw, rfm, sz};
  endfunction

  task automatic test_reset();
    reset = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0; ms_allowin = 1'b1;
    alu_result = 32'h1234_5678; alu_complete = 1'b0;
    #2;
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", es_to_ms_valid); end
    total++; if (es_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%0h exp=1", es_allowin); end
    total++; if (alu_op !== 19'd0) begin bad++; $display("FAIL rst_alu_op got=%0h exp=0", alu_op); end
    total++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'd0) begin bad++; $display("FAIL rst_sram got=%0h/%0h exp=0/0", data_sram_en, data_sram_we); end
    total++; if (es_fwd_valid !== 1'b0 || es_fwd_block !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%0h/%0h exp=0/0", es_fwd_valid, es_fwd_block); end
    total++; if (es_to_ms_bus !== 75'd0 || data_sram_addr !== 32'd0 || es_fwd_data !== 32'd0) begin bad++; $display("FAIL rst_bus got=%0h exp=0", es_to_ms_bus); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    ds_to_es_valid = 1'b1; ms_allowin = 1'b1; alu_complete = 1'b1; alu_result = 32'd12;
    ds_to_es_bus = mk(32'h0000_1000, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #1; ds_to_es_valid = 1'b0;
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0h exp=1", es_to_ms_valid); end
    total++; if (es_to_ms_bus[42:11] !== 32'd12) begin bad++; $display("FAIL add_result got=%0h exp=c", es_to_ms_bus[42:11]); end
    total++; if (alu_op !== OP_ADD || alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin bad++; $display("FAIL add_alu got=%0h %0h %0h", alu_op, alu_src1, alu_src2); end
    total++; if (es_fwd_data !== (FWD ? 32'd12 : 32'd0) || es_fwd_valid !== FWD) begin bad++; $display("FAIL add_fwd got=%0h/%0h exp=%0h", es_fwd_data, es_fwd_valid, FWD); end
    total++; if (es_fwd_block !== ~FWD || es_fwd_rd !== 5'd3) begin bad++; $display("FAIL add_block got=%0h rd=%0d exp=%0h rd=3", es_fwd_block, es_fwd_rd, ~FWD); end
    total++; if (data_sram_en !== 1'b0 || es_allowin !== 1'b1) begin bad++; $display("FAIL add_en_allowin got=%0h/%0h exp=0/1", data_sram_en, es_allowin); end
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0h exp=0", es_to_ms_valid); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    ds_to_es_valid = 1'b1; ms_allowin = 1'b1; alu_complete = 1'b1;
    ds_to_es_bus = mk(32'h0000_2000, OP_ADD, 32'd1, 32'd2, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #1;
    alu_result = 32'd3;
    ds_to_es_bus = mk(32'h0000_2004, OP_ADD, 32'd10, 32'd20, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[42:11] !== 32'd3 || es_allowin !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0h res=%0h allow=%0h", es_to_ms_valid, es_to_ms_bus[42:11], es_allowin); end
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0; alu_result = 32'd30;
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[74:43] !== 32'h0000_2004 || es_to_ms_bus[42:11] !== 32'd30 || es_to_ms_bus[10:6] !== 5'd7) begin bad++; $display("FAIL b2b_second got=%0h pc=%0h res=%0h", es_to_ms_valid, es_to_ms_bus[74:43], es_to_ms_bus[42:11]); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_backpressure();
    int stall_bad = 0;
    ds_to_es_valid = 1'b1; ms_allowin = 1'b0; alu_complete = 1'b0; alu_result = 32'h0;
    ds_to_es_bus = mk(32'h0000_3000, OP_DIV, 32'd100, 32'd7, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #1; ds_to_es_valid = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (es_allowin !== 1'b0 || es_to_ms_valid !== 1'b0 || alu_op !== OP_DIV || es_fwd_block !== 1'b1) stall_bad++;
      @(posedge clk); #1;
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL div_stall bad_cycles got=%0d exp=0", stall_bad); end
    alu_complete = 1'b1; alu_result = 32'd14;
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0 || data_sram_en !== 1'b0) begin bad++; $display("FAIL div_complete got=%0h/%0h/%0h exp=1/0/0", es_to_ms_valid, es_allowin, data_sram_en); end
    @(posedge clk); #1;
    alu_complete = 1'b0; alu_result = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[42:11] !== 32'd14) begin bad++; $display("FAIL div_held got=%0h res=%0h exp=1 res=e", es_to_ms_valid, es_to_ms_bus[42:11]); end
    total++; if (alu_op !== 19'd0 || es_allowin !== 1'b0) begin bad++; $display("FAIL div_op_after_done got=%0h allow=%0h exp=0/0", alu_op, es_allowin); end
    total++; if (es_fwd_block !== ~FWD || es_fwd_data !== (FWD ? 32'd14 : 32'd0)) begin bad++; $display("FAIL div_fwd got=%0h/%0h", es_fwd_block, es_fwd_data); end
    @(posedge clk); #1; ms_allowin = 1'b1;
    @(negedge clk);
    total++; if (es_allowin !== 1'b1 || es_to_ms_bus[42:11] !== 32'd14) begin bad++; $display("FAIL div_handoff got=%0h res=%0h exp=1 res=e", es_allowin, es_to_ms_bus[42:11]); end
    @(negedge clk);
    total++; if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL div_drain got=%0h exp=0", es_to_ms_valid); end
  endtask

  task automatic test_store();
    int pulses = 0;
    logic [31:0] addr_t [3] = '{32'h0000_1003, 32'h0000_2002, 32'h0000_3001};
    logic [31:0] rkd_t  [3] = '{32'hAABB_CCDD, 32'h1122_3344, 32'h5566_7788};
    logic [1:0]  sz_t   [3] = '{2'd0, 2'd1, 2'd2};
    logic [3:0]  we_t   [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wd_t   [3] = '{32'hDDDD_DDDD, 32'h3344_3344, 32'h5566_7788};
    for (int k = 0; k < 3; k++) begin
      pulses = 0;
      @(posedge clk); #1;
      ds_to_es_valid = 1'b1; ms_allowin = 1'b0; alu_complete = 1'b1; alu_result = addr_t[k];
      ds_to_es_bus = mk(32'h0000_4000, OP_ADD, addr_t[k] - 32'd3, 32'd3, rkd_t[k], 5'd0, 1'b0, 1'b1, 1'b0, sz_t[k]);
      @(posedge clk); #1; ds_to_es_valid = 1'b0;
      @(negedge clk); if (data_sram_en === 1'b1) pulses++;
      total++; if (data_sram_we !== we_t[k] || data_sram_wdata !== wd_t[k] || data_sram_addr !== addr_t[k]) begin bad++; $display("FAIL store%0d_lanes got=%0h/%0h/%0h exp=%0h/%0h/%0h", k, data_sram_we, data_sram_wdata, data_sram_addr, we_t[k], wd_t[k], addr_t[k]); end
      @(posedge clk); #1; ms_allowin = 1'b1; alu_complete = 1'b0; alu_result = 32'd0;
      @(negedge clk); if (data_sram_en === 1'b1) pulses++;
      total++; if (data_sram_addr !== addr_t[k] || data_sram_we !== we_t[k]) begin bad++; $display("FAIL store%0d_latched got=%0h/%0h exp=%0h/%0h", k, data_sram_addr, data_sram_we, addr_t[k], we_t[k]); end
      @(negedge clk); if (data_sram_en === 1'b1) pulses++;
      total++; if (pulses !== 1) begin bad++; $display("FAIL store%0d_en_pulses got=%0d exp=1", k, pulses); end
    end
  endtask

  task automatic test_load_interlock();
    @(posedge clk); #1;
    ds_to_es_valid = 1'b1; ms_allowin = 1'b0; alu_complete = 1'b1; alu_result = 32'h0000_0100;
    ds_to_es_bus = mk(32'h0000_5000, OP_ADD, 32'h100, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 2'd2);
    @(posedge clk); #1; ds_to_es_valid = 1'b0;
    @(negedge clk);
    total++; if (es_fwd_block !== 1'b1 || es_fwd_rd !== 5'd4) begin bad++; $display("FAIL load_block got=%0h rd=%0d exp=1 rd=4", es_fwd_block, es_fwd_rd); end
    total++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'd0) begin bad++; $display("FAIL load_hold_en got=%0h/%0h exp=0/0", data_sram_en, data_sram_we); end
    @(posedge clk); #1; ms_allowin = 1'b1;
    @(negedge clk);
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'd0 || data_sram_addr !== 32'h100) begin bad++; $display("FAIL load_en got=%0h/%0h/%0h exp=1/0/100", data_sram_en, data_sram_we, data_sram_addr); end
    @(posedge clk); #1;
    ds_to_es_valid = 1'b1; alu_complete = 1'b1; alu_result = 32'd9;
    ds_to_es_bus = mk(32'h0000_5004, OP_ADD, 32'd4, 32'd5, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #1;
    ds_to_es_bus = mk(32'h0000_5008, OP_ADD, 32'd4, 32'd5, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    total++; if (es_fwd_block !== ~FWD) begin bad++; $display("FAIL add_rd4_block got=%0h exp=%0h", es_fwd_block, ~FWD); end
    @(posedge clk); #1; ds_to_es_valid = 1'b0;
    @(negedge clk);
    total++; if (es_fwd_block !== 1'b0 || es_fwd_valid !== 1'b0 || es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL add_rd0_block got=%0h/%0h/%0h exp=0/0/1", es_fwd_block, es_fwd_valid, es_to_ms_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    ds_to_es_valid = 1'b1; ms_allowin = 1'b1; alu_complete = 1'b0; alu_result = 32'd0;
    ds_to_es_bus = mk(32'h0000_6000, OP_DIV, 32'd50, 32'd3, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #1; ds_to_es_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (alu_op !== OP_DIV || es_allowin !== 1'b0) begin bad++; $display("FAIL middiv_busy got=%0h/%0h", alu_op, es_allowin); end
    #1; reset = 1'b1; #1;
    total++; if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || alu_op !== 19'd0) begin bad++; $display("FAIL middiv_reset got=%0h/%0h/%0h exp=0/1/0", es_to_ms_valid, es_allowin, alu_op); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div_backpressure();
    test_store();
    test_load_interlock();
    test_reset_mid_div();
    test_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
